// File: rtl/cnn_result_sink.sv
// Classifier output sink: buffers one frame of class scores and
// reports the signed argmax with a one-cycle done pulse.
module cnn_result_sink #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_CLASS  = 10,
    parameter int IDX_WIDTH  = 4,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [IDX_WIDTH-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_WIDTH-1:0]  class_idx,
    output logic [DATA_WIDTH-1:0] class_val,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);

    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASS - 1);
    localparam logic [IDX_WIDTH:0]   NCLS = (IDX_WIDTH + 1)'(NUM_CLASS);

    logic [IDX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] run_val_q, run_val_d;
    logic [IDX_WIDTH-1:0]  run_idx_q, run_idx_d;
    logic [IDX_WIDTH-1:0]  class_idx_q, class_idx_d;
    logic [DATA_WIDTH-1:0] class_val_q, class_val_d;
    logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] sbuf_q [NUM_CLASS];

    logic                  accept;
    logic                  take;
    logic [DATA_WIDTH-1:0] cand_val;
    logic [IDX_WIDTH-1:0]  cand_idx;

    assign accept = in_valid & ~clear;

    // Element 0 always seeds the running max; later ones need a strict win.
    assign take     = (cnt_q == '0) ||
                      ($signed(in_data) > $signed(run_val_q));
    assign cand_val = take ? in_data : run_val_q;
    assign cand_idx = take ? cnt_q : run_idx_q;

    always_comb begin
        cnt_d       = cnt_q;
        run_val_d   = run_val_q;
        run_idx_d   = run_idx_q;
        class_idx_d = class_idx_q;
        class_val_d = class_val_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            run_val_d = cand_val;
            run_idx_d = cand_idx;
            if (cnt_q == LAST) begin
                cnt_d       = '0;
                class_val_d = cand_val;
                class_idx_d = cand_idx;
                frame_cnt_d = frame_cnt_q + FCNT_WIDTH'(1);
                done_d      = 1'b1;
            end else begin
                cnt_d = cnt_q + IDX_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            run_val_q   <= '0;
            run_idx_q   <= '0;
            class_idx_q <= '0;
            class_val_q <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            run_val_q   <= run_val_d;
            run_idx_q   <= run_idx_d;
            class_idx_q <= class_idx_d;
            class_val_q <= class_val_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CLASS; i++) sbuf_q[i] <= '0;
        end else if (accept) begin
            sbuf_q[cnt_q] <= in_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < NCLS) rd_data = sbuf_q[rd_addr];
    end

    assign busy      = (cnt_q != '0);
    assign done      = done_q;
    assign class_idx = class_idx_q;
    assign class_val = class_val_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cnn_result_sink.sv
// Directed + randomized bench for cnn_result_sink against a
// frame-level argmax reference model.
module tb_cnn_result_sink;

    localparam int DW = 24;
    localparam int NC = 10;
    localparam int IW = 4;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [IW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic [IW-1:0] class_idx;
    logic [DW-1:0] class_val;
    logic [FW-1:0] frame_cnt;

    int nvec = 0;
    int nerr = 0;

    logic [DW-1:0] mbuf [16];
    logic [DW-1:0] cur [NC];
    int            mcnt;
    int            midx;
    logic [DW-1:0] mval;
    logic [FW-1:0] mframe;

    always #5 clk = ~clk;

    cnn_result_sink #(
        .DATA_WIDTH(DW), .NUM_CLASS(NC),
        .IDX_WIDTH(IW), .FCNT_WIDTH(FW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data(in_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done),
        .class_idx(class_idx), .class_val(class_val),
        .frame_cnt(frame_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mbuf[i] = '0;
        mcnt = 0; midx = 0; mval = '0; mframe = '0;
    endtask

    // Reference: first index holding the largest signed score.
    task automatic argmax();
        midx = 0;
        for (int i = 1; i < NC; i++)
            if ($signed(cur[i]) > $signed(cur[midx])) midx = i;
        mval = cur[midx];
    endtask

    task automatic idle(input int n);
        for (int g = 0; g < n; g++) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            chk("idle_done", {31'b0, done}, 32'd0);
        end
    endtask

    task automatic send(input logic [DW-1:0] d, input int gap);
        int  k;
        logic fin;
        idle(gap);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = mcnt;
        cur[k]  = d;
        mbuf[k] = d;
        mcnt++;
        fin = (mcnt == NC);
        if (fin) begin
            mcnt = 0;
            argmax();
            mframe = mframe + 1'b1;
        end
        chk("done", {31'b0, done}, {31'b0, fin});
        chk("busy", {31'b0, busy}, {31'b0, mcnt != 0});
        if (fin) begin
            chk("class_idx", {28'b0, class_idx}, midx);
            chk("class_val", {8'b0, class_val}, {8'b0, mval});
            chk("frame_cnt", {16'b0, frame_cnt}, {16'b0, mframe});
        end
        rd_addr = IW'(k);
        #1;
        chk("write_thru", {8'b0, rd_data}, {8'b0, d});
    endtask

    task automatic check_buf();
        for (int a = 0; a < 16; a++) begin
            rd_addr = IW'(a);
            #1;
            chk("rd_data", {8'b0, rd_data}, {8'b0, mbuf[a]});
        end
    endtask

    task automatic check_result();
        chk("hold_idx", {28'b0, class_idx}, midx);
        chk("hold_val", {8'b0, class_val}, {8'b0, mval});
        chk("hold_cnt", {16'b0, frame_cnt}, {16'b0, mframe});
    endtask

    initial begin
        logic [DW-1:0] fa [NC];
        logic [FW-1:0] f0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset values
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        check_result();
        check_buf();

        // contiguous frame, tie keeps lower index
        fa = '{-24'sd5, 24'd3, 24'd7, 24'd7, -24'sd1,
               24'd0, 24'd2, 24'd6, 24'd1, -24'sd8};
        for (int i = 0; i < NC; i++) send(fa[i], 0);
        chk("tie_idx", {28'b0, class_idx}, 32'd2);
        chk("tie_val", {8'b0, class_val}, 32'd7);
        idle(1);
        rd_addr = 4'd9; #1;
        chk("rd9", {8'b0, rd_data}, 32'hFFFFF8);
        rd_addr = 4'd12; #1;
        chk("rd12", {8'b0, rd_data}, 32'd0);

        // signed extremes with random gaps
        fa = '{24'h800000, 24'h7FFFFF, 24'd0, 24'd0, 24'd0,
               24'd0, 24'd0, 24'd0, 24'd0, 24'hFFFFFF};
        for (int i = 0; i < NC; i++) send(fa[i], $urandom_range(0, 3));
        chk("ext_idx", {28'b0, class_idx}, 32'd1);
        for (int i = 0; i < NC; i++)
            send(DW'(i - 10), $urandom_range(0, 3));
        chk("neg_val", {8'b0, class_val}, 32'hFFFFFF);
        idle(2);
        check_result();

        // abort: clear wins over a same-cycle beat
        for (int i = 0; i < 4; i++) send(DW'($urandom), 0);
        clear = 1'b1; in_valid = 1'b1; in_data = 24'h123456;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        mcnt = 0;
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_done", {31'b0, done}, 32'd0);
        check_result();
        f0 = mframe;
        for (int i = 0; i < NC; i++) send(DW'(i + 1), 0);
        chk("abort_idx", {28'b0, class_idx}, 32'd9);
        chk("abort_fc", {16'b0, frame_cnt}, {16'b0, f0 + 16'd1});
        idle(1);

        // back-to-back frames
        fa = '{24'd1, 24'd2, 24'd0, 24'd5, 24'd4,
               24'd3, 24'd1, 24'd0, 24'd2, 24'd5};
        for (int i = 0; i < NC; i++) send(fa[i], 0);
        chk("bbA_idx", {28'b0, class_idx}, 32'd3);
        fa = '{24'd9, 24'd8, 24'd1, 24'd9, 24'd0,
               24'd3, 24'd7, 24'd2, 24'd6, 24'd9};
        for (int i = 0; i < NC; i++) send(fa[i], 0);
        chk("bbB_idx", {28'b0, class_idx}, 32'd0);
        idle(1);

        // randomized frames
        for (int f = 0; f < 12; f++)
            for (int i = 0; i < NC; i++)
                send(DW'($urandom), $urandom_range(0, 2));
        idle(1);
        check_buf();

        // mid-frame async reset
        for (int i = 0; i < 5; i++) send(DW'($urandom), 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_busy", {31'b0, busy}, 32'd0);
        chk("mrst_done", {31'b0, done}, 32'd0);
        check_result();
        check_buf();
        @(posedge clk); #1 rst_n = 1'b1;
        idle(2);

        // frame counter wrap
        for (int i = 0; i < NC; i++) send(DW'($urandom), 0);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        mframe = 16'hFFFF;
        for (int i = 0; i < NC; i++) send(DW'($urandom), 1);
        chk("wrap_cnt", {16'b0, frame_cnt}, 32'd0);
        idle(2);
        check_result();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
